// File: rtl/reg_io_bridge.sv
// Bridges board I/O to the register file: a valid/ready source drives the regfile IO write
// port, and a snapshot of the exported register window is streamed out one word at a time.
module reg_io_bridge #(
   parameter int unsigned NUM_WORDS    = 8,
   parameter int unsigned BASE_REG     = 3,
   parameter int unsigned WAIT_TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [4:0]                in_addr,
   input  logic [31:0]               in_data,
   output logic                      in_done,
   output logic                      in_err,
   input  logic                      reg_IO_out_ena,
   output logic [4:0]                input_address,
   output logic [31:0]               input_num,
   input  logic [32*NUM_WORDS-1:0]   from_reg,
   input  logic                      dump_req,
   output logic                      dump_busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_data,
   output logic [4:0]                out_reg_num,
   output logic                      out_last,
   output logic                      dump_done
);

   localparam int unsigned IdxW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned CntW      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam int unsigned TimeoutM1 = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
   localparam int unsigned LastIdx   = NUM_WORDS - 1;

   typedef enum logic [1:0] {WIdle, WWait, WDrive} w_state_e;
   typedef enum logic [0:0] {DIdle, DSend} d_state_e;

   // ---------------- Write path ----------------
   w_state_e          w_state_q, w_state_d;
   logic [4:0]        addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= WIdle;
         addr_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (in_valid) begin
               addr_d = in_addr;
               data_d = in_data;
               if (in_addr == 5'd0) begin
                  err_d = 1'b1;
               end else begin
                  w_state_d = WWait;
                  cnt_d     = '0;
               end
            end
         end
         WWait: begin
            if (reg_IO_out_ena) begin
               w_state_d = WDrive;
            end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CntW'(TimeoutM1))) begin
               w_state_d = WIdle;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WDrive:  w_state_d = WIdle;
         default: w_state_d = WIdle;
      endcase
   end

   // The regfile writes on the negedge inside the single WDrive cycle.
   always_comb begin
      in_ready      = (w_state_q == WIdle);
      in_done       = (w_state_q == WDrive);
      in_err        = err_q;
      input_address = (w_state_q == WDrive) ? addr_q : 5'd0;
      input_num     = (w_state_q == WDrive) ? data_q : 32'd0;
   end

   // ---------------- Dump path ----------------
   d_state_e          d_state_q, d_state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              done_q, done_d;
   logic              snap_load;
   logic [31:0]       snap_q [NUM_WORDS];
   logic              is_last;

   assign is_last = (idx_q == IdxW'(LastIdx));

   always_ff @(posedge clk) begin
      if (rst) begin
         d_state_q <= DIdle;
         idx_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         d_state_q <= d_state_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
      end
   end

   // Snapshot isolates the stream from later register updates.
   always_ff @(posedge clk) begin
      if (snap_load) begin
         for (int k = 0; k < int'(NUM_WORDS); k++) begin
            snap_q[k] <= from_reg[32*k +: 32];
         end
      end
   end

   always_comb begin
      d_state_d = d_state_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      snap_load = 1'b0;
      unique case (d_state_q)
         DIdle: begin
            if (dump_req && !rst) begin
               d_state_d = DSend;
               idx_d     = '0;
               snap_load = 1'b1;
            end
         end
         DSend: begin
            if (out_ready) begin
               if (is_last) begin
                  d_state_d = DIdle;
                  idx_d     = '0;
                  done_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: d_state_d = DIdle;
      endcase
   end

   always_comb begin
      dump_busy   = (d_state_q == DSend);
      out_valid   = (d_state_q == DSend);
      out_data    = (d_state_q == DSend) ? snap_q[idx_q] : 32'd0;
      out_reg_num = (d_state_q == DSend) ? 5'(BASE_REG) + 5'(idx_q) : 5'd0;
      out_last    = (d_state_q == DSend) && is_last;
      dump_done   = done_q;
   end

endmodule

// File: tb/tb_reg_io_bridge.sv
// Directed self-checking bench for reg_io_bridge: writes, address-0 drop, timeout,
// streaming dump with backpressure and mid-operation reset.
module tb_reg_io_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [4:0]   in_addr;
   logic [31:0]  in_data;
   logic         in_done;
   logic         in_err;
   logic         reg_IO_out_ena;
   logic [4:0]   input_address;
   logic [31:0]  input_num;
   logic [255:0] from_reg;
   logic         dump_req;
   logic         dump_busy;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [4:0]   out_reg_num;
   logic         out_last;
   logic         dump_done;

   int n_chk  = 0;
   int n_pass = 0;

   reg_io_bridge #(
      .NUM_WORDS   (8),
      .BASE_REG    (3),
      .WAIT_TIMEOUT(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_addr       (in_addr),
      .in_data       (in_data),
      .in_done       (in_done),
      .in_err        (in_err),
      .reg_IO_out_ena(reg_IO_out_ena),
      .input_address (input_address),
      .input_num     (input_num),
      .from_reg      (from_reg),
      .dump_req      (dump_req),
      .dump_busy     (dump_busy),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_reg_num   (out_reg_num),
      .out_last      (out_last),
      .dump_done     (dump_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // All DUT outputs are registered-state functions, so sampling 1 ns after the edge is safe.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] base);
      for (int k = 0; k < 8; k++) from_reg[32*k +: 32] = base + 32'(k);
   endtask

   initial begin
      int cyc;
      int drv_seen;
      int e;

      rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; reg_IO_out_ena = 1'b0;
      from_reg = '0; dump_req = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_in_err", 32'(in_err), 32'd0);
      chk("rst_in_done", 32'(in_done), 32'd0);
      chk("rst_input_address", 32'(input_address), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dump_busy", 32'(dump_busy), 32'd0);
      rst = 1'b0;
      tick();

      // 1: basic write with ena already high
      reg_IO_out_ena = 1'b1;
      in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      chk("w1_wait_ready", 32'(in_ready), 32'd0);
      chk("w1_wait_addr", 32'(input_address), 32'd0);
      tick();
      chk("w1_drive_addr", 32'(input_address), 32'd5);
      chk("w1_drive_num", input_num, 32'hDEAD_BEEF);
      chk("w1_done", 32'(in_done), 32'd1);
      tick();
      chk("w1_post_addr", 32'(input_address), 32'd0);
      chk("w1_post_num", input_num, 32'd0);
      chk("w1_post_done", 32'(in_done), 32'd0);
      chk("w1_post_ready", 32'(in_ready), 32'd1);

      // 2: address 0 is dropped with an error pulse
      in_valid = 1'b1; in_addr = 5'd0; in_data = 32'd1;
      tick();
      in_valid = 1'b0;
      chk("w2_err", 32'(in_err), 32'd1);
      chk("w2_addr", 32'(input_address), 32'd0);
      chk("w2_ready", 32'(in_ready), 32'd1);
      tick();
      chk("w2_err_gone", 32'(in_err), 32'd0);
      chk("w2_no_done", 32'(in_done), 32'd0);

      // 3a: timeout with ena low
      reg_IO_out_ena = 1'b0;
      in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h77;
      tick();
      in_valid = 1'b0;
      cyc = 0; drv_seen = 0;
      while (in_err !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
         if (input_address != 5'd0) drv_seen++;
      end
      chk("w3_timeout_cycles", 32'(cyc), 32'd16);
      chk("w3_no_drive", 32'(drv_seen), 32'd0);
      chk("w3_ready_after", 32'(in_ready), 32'd1);
      tick();

      // 3b: ena raised after 10 waiting cycles
      in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h1234_5678;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("w3b_still_wait", 32'(in_ready), 32'd0);
      reg_IO_out_ena = 1'b1;
      tick();
      chk("w3b_drive_addr", 32'(input_address), 32'd7);
      chk("w3b_drive_num", input_num, 32'h1234_5678);
      chk("w3b_done", 32'(in_done), 32'd1);
      chk("w3b_no_err", 32'(in_err), 32'd0);
      tick();
      chk("w3b_post_err", 32'(in_err), 32'd0);
      chk("w3b_post_addr", 32'(input_address), 32'd0);

      // 4: full dump with no backpressure
      fill(32'h1000_0000);
      out_ready = 1'b1; dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("d4_valid", 32'(out_valid), 32'd1);
         chk("d4_data", out_data, 32'h1000_0000 + 32'(k));
         chk("d4_regnum", 32'(out_reg_num), 32'(3 + k));
         chk("d4_last", 32'(out_last), (k == 7) ? 32'd1 : 32'd0);
         tick();
      end
      chk("d4_done", 32'(dump_done), 32'd1);
      chk("d4_idle_valid", 32'(out_valid), 32'd0);
      chk("d4_idle_busy", 32'(dump_busy), 32'd0);
      tick();
      chk("d4_done_gone", 32'(dump_done), 32'd0);

      // 5: backpressure, source changes mid-stream, stray dump_req while busy
      fill(32'h2000_0000);
      out_ready = 1'b0; dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      fill(32'hBAD0_0000);
      e = 0; cyc = 0;
      while (e < 8 && cyc < 40) begin
         chk("d5_valid", 32'(out_valid), 32'd1);
         chk("d5_data", out_data, 32'h2000_0000 + 32'(e));
         chk("d5_regnum", 32'(out_reg_num), 32'(3 + e));
         chk("d5_last", 32'(out_last), (e == 7) ? 32'd1 : 32'd0);
         out_ready = (cyc % 3 != 1);
         dump_req  = (cyc == 2 || cyc == 3);
         tick();
         if (out_ready) e++;
         cyc++;
      end
      out_ready = 1'b0; dump_req = 1'b0;
      chk("d5_words", 32'(e), 32'd8);
      chk("d5_done", 32'(dump_done), 32'd1);
      chk("d5_idle", 32'(out_valid), 32'd0);
      tick();
      chk("d5_no_restart", 32'(dump_busy), 32'd0);

      // 6: reset during W_WAIT and mid-dump
      reg_IO_out_ena = 1'b0;
      in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
      dump_req = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0; dump_req = 1'b0;
      out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      chk("r6_busy_before", 32'(dump_busy), 32'd1);
      chk("r6_wait_before", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      chk("r6_in_ready", 32'(in_ready), 32'd1);
      chk("r6_busy", 32'(dump_busy), 32'd0);
      chk("r6_valid", 32'(out_valid), 32'd0);
      chk("r6_data", out_data, 32'd0);
      chk("r6_err", 32'(in_err), 32'd0);
      chk("r6_done", 32'(dump_done), 32'd0);
      rst = 1'b0;
      reg_IO_out_ena = 1'b1; out_ready = 1'b1;
      drv_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (input_address != 5'd0 || in_err || in_done || dump_done || out_valid) drv_seen++;
      end
      chk("r6_no_pulses", 32'(drv_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
